inst_sram_responder: RTL and testbench

- Responder (slave) end of the sram-like req/addr_ok/data_ok interface that the IF and MEM stages drive as initiators.
- Wraps a word-addressed on-chip memory array.
- Accepts requests in order, queues up to DEPTH outstanding transactions, and returns exactly one data_ok per accepted request, strictly in order and no earlier than LAT cycles after acceptance.
- Used as the instruction/data SRAM model in the SoC-lite top and in stage-level benches.

---
 rtl/inst_sram_responder.sv | 163 ++++++++++++++++
 tb/tb_inst_sram_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_responder.sv
// Responder end of the sram-like req/addr_ok/data_ok interface wrapping a word-addressed 32-bit array.
// Optional feature RESP_RANDOM_DELAY_EN: an LFSR inserts random addr_ok/data_ok wait states.
module inst_sram_responder #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 2,
    parameter int LAT    = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req,
    input  logic                   wr,
    input  logic [1:0]             size,
    input  logic [3:0]             wstrb,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic                   addr_ok,
    output logic                   data_ok,
    output logic [31:0]            rdata,
    output logic [$clog2(DEPTH):0] outstanding
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(LAT + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_SAT  = TMR_W'(LAT);

    logic [31:0]       mem_r [0:(1<<ADDR_W)-1];
    logic [DEPTH-1:0]  ent_vld_r;
    logic              ent_wr_r    [DEPTH];
    logic [1:0]        ent_size_r  [DEPTH];
    logic [3:0]        ent_wstrb_r [DEPTH];
    logic [ADDR_W-1:0] ent_idx_r   [DEPTH];
    logic [31:0]       ent_wdata_r [DEPTH];
    logic [TMR_W-1:0]  ent_tmr_r   [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [1:0]        rel_sync_r;
    logic [31:0]       rdata_r;

    logic              released_s;
    logic              hold_aok_s;
    logic              hold_dok_s;
    logic              head_ready_s;
    logic              head_wr_s;
    logic              pop_s;
    logic              accept_s;
    logic              push_s;
    logic [ADDR_W-1:0] head_idx_s;
    logic [31:0]       mem_rd_s;
    logic              unused_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

`ifdef RESP_RANDOM_DELAY_EN
    logic [15:0] lfsr_r;

    // Free-running wait-state generator, reloaded with its seed on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end

    assign hold_aok_s = lfsr_r[0];
    assign hold_dok_s = lfsr_r[1];
`else
    assign hold_aok_s = 1'b0;
    assign hold_dok_s = 1'b0;
`endif

    // Head readiness, handshake decode and combinational array read.
    always_comb begin
        head_idx_s   = ent_idx_r[head_r];
        head_wr_s    = ent_wr_r[head_r];
        mem_rd_s     = mem_r[head_idx_s];
        head_ready_s = ent_vld_r[head_r] && (ent_tmr_r[head_r] >= TMR_SAT);
        pop_s        = head_ready_s && !hold_dok_s;
        accept_s     = released_s && ((count_r < CNT_FULL) || pop_s) && !hold_aok_s;
        push_s       = req && accept_s;
    end

    assign released_s  = rel_sync_r[1];
    assign addr_ok     = accept_s;
    assign data_ok     = pop_s;
    assign outstanding = count_r;
    assign rdata       = (pop_s && !head_wr_s) ? mem_rd_s : rdata_r;
    // size is carried only for observation; the upper and byte address bits alias.
    assign unused_s    = ^{ent_size_r[head_r], size, addr};

    // Two-flop synchronised reset release and last-read data hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rel_sync_r <= 2'b00;
            rdata_r    <= 32'h0000_0000;
        end else begin
            rel_sync_r <= {rel_sync_r[0], 1'b1};
            if (pop_s && !head_wr_s) begin
                rdata_r <= mem_rd_s;
            end
        end
    end

    // In-order request queue; a timer counts edges since acceptance, the handshake edge included.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ent_vld_r <= {DEPTH{1'b0}};
            head_r    <= PTR_W'(0);
            tail_r    <= PTR_W'(0);
            count_r   <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                ent_wr_r[i]    <= 1'b0;
                ent_size_r[i]  <= 2'b00;
                ent_wstrb_r[i] <= 4'b0000;
                ent_idx_r[i]   <= ADDR_W'(0);
                ent_wdata_r[i] <= 32'h0000_0000;
                ent_tmr_r[i]   <= TMR_W'(0);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_vld_r[i] && (ent_tmr_r[i] < TMR_SAT)) begin
                    ent_tmr_r[i] <= ent_tmr_r[i] + TMR_W'(1);
                end
            end
            if (pop_s) begin
                ent_vld_r[head_r] <= 1'b0;
                head_r            <= ptr_next(head_r);
            end
            // Push follows pop so a full-queue push/pop reuses the freed slot.
            if (push_s) begin
                ent_vld_r[tail_r]   <= 1'b1;
                ent_wr_r[tail_r]    <= wr;
                ent_size_r[tail_r]  <= size;
                ent_wstrb_r[tail_r] <= wstrb;
                ent_idx_r[tail_r]   <= addr[ADDR_W+1:2];
                ent_wdata_r[tail_r] <= wdata;
                ent_tmr_r[tail_r]   <= TMR_W'(1);
                tail_r              <= ptr_next(tail_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Byte-lane write commit at the write's own completion; array contents survive reset.
    always_ff @(posedge clk) begin
        if (pop_s && head_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (ent_wstrb_r[head_r][b]) begin
                    mem_r[head_idx_s][8*b +: 8] <= ent_wdata_r[head_r][8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_sram_responder.sv
// Self-checking bench for inst_sram_responder: directed scenarios plus randomized traffic
// against a transaction-queue reference model (handshake cycle + LAT, in-order completion).
module tb_inst_sram_responder;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 2;
    localparam int LAT    = 3;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        req    = 1'b0;
    logic        wr     = 1'b0;
    logic [1:0]  size   = 2'd2;
    logic [3:0]  wstrb  = 4'h0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic [$clog2(DEPTH):0] outstanding;

    inst_sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          hs;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    txn_t        q[$];
    bit   [31:0] mem_m [int];
    logic [31:0] rdata_m = 32'h0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    logic        exp_aok, exp_dok, obs_aok, obs_dok;
    logic [31:0] exp_rdata, obs_rdata;
    int          exp_out;
    logic [$clog2(DEPTH):0] obs_out;

    function automatic int widx(input logic [31:0] a);
        return int'(a[ADDR_W+1:2]);
    endfunction

    function automatic logic [31:0] mem_get(input int i);
        return mem_m.exists(i) ? mem_m[i] : 32'h0;
    endfunction

    // One clock cycle: apply inputs, predict outputs from the model, sample at negedge, advance model.
    task automatic drive_cycle(input bit r, input bit w, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] d);
        bit          do_pop, do_push;
        txn_t        e;
        logic [31:0] v;
        req = r; wr = w; addr = a; wstrb = s; wdata = d;
        exp_dok   = (q.size() > 0) && (cyc >= q[0].hs + LAT);
        exp_aok   = (q.size() < DEPTH) || exp_dok;
        exp_out   = q.size();
        exp_rdata = ((q.size() > 0) && !q[0].wr) ? mem_get(widx(q[0].addr)) : rdata_m;
        @(negedge clk);
        obs_aok = addr_ok; obs_dok = data_ok; obs_rdata = rdata; obs_out = outstanding;
`ifdef RESP_RANDOM_DELAY_EN
        do_pop  = obs_dok;
        do_push = r && obs_aok;
`else
        do_pop  = exp_dok;
        do_push = r && exp_aok;
`endif
        @(posedge clk);
        if (do_pop) begin
            e = q.pop_front();
            if (e.wr) begin
                v = mem_get(widx(e.addr));
                for (int b = 0; b < 4; b++)
                    if (e.wstrb[b]) v[8*b +: 8] = e.wdata[8*b +: 8];
                mem_m[widx(e.addr)] = v;
            end else begin
                rdata_m = mem_get(widx(e.addr));
            end
        end
        if (do_push) q.push_back('{cyc, w, a, s, d});
        cyc++;
        #1;
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        for (int t = 0; t < 50; t++) begin
            drive_cycle(1'b1, w, a, s, d);
            if (obs_aok) begin
                req = 1'b0;
                return;
            end
        end
        n_cmp++; n_fail++;
        $display("FAIL issue_timeout addr=%h got no addr_ok want addr_ok within 50 cycles", a);
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            if (q.size() == 0) return;
            drive_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        end
        n_cmp++; n_fail++;
        $display("FAIL drain_timeout got %0d pending want 0", q.size());
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (addr_ok !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ok got %b want 0", addr_ok); end
        n_cmp++; if (data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok got %b want 0", data_ok); end
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_cmp++; if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) drive_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
`ifndef RESP_RANDOM_DELAY_EN
        drive_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        n_cmp++; if (obs_aok !== 1'b1) begin n_fail++; $display("FAIL release_addr_ok got %b want 1", obs_aok); end
`endif
    endtask

    task automatic test_single_read();
        issue(1'b1, 32'h0000_1C00, 4'hF, 32'h0280_0C0C);
        drain();
        drive_cycle(1'b1, 1'b0, 32'h0000_1C00, 4'h0, 32'h0);
        req = 1'b0;
        n_cmp++; if (obs_aok !== 1'b1) begin n_fail++; $display("FAIL single_accept got %b want 1", obs_aok); end
        for (int k = 1; k <= LAT + 1; k++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            n_cmp++;
            if (obs_dok !== (k == LAT)) begin
                n_fail++; $display("FAIL single_data_ok_k%0d got %b want %b", k, obs_dok, (k == LAT));
            end
            if (k == LAT) begin
                n_cmp++; if (obs_rdata !== 32'h0280_0C0C) begin n_fail++; $display("FAIL single_rdata got %h want 02800c0c", obs_rdata); end
                n_cmp++; if (obs_out !== 2'd1) begin n_fail++; $display("FAIL single_outstanding got %0d want 1", obs_out); end
            end
        end
        n_cmp++; if (obs_out !== 2'd0) begin n_fail++; $display("FAIL single_outstanding_end got %0d want 0", obs_out); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, done = 0, drops = 0;
        for (int i = 0; i < 4; i++) issue(1'b1, 32'(4 * i), 4'hF, 32'hA000_0000 + 32'(i));
        drain();
        for (int t = 0; t < 40 && done < 4; t++) begin
            drive_cycle(sent < 4, 1'b0, 32'(4 * sent), 4'h0, 32'h0);
            n_cmp++; if (obs_aok !== exp_aok) begin n_fail++; $display("FAIL b2b_addr_ok c%0d got %b want %b", t, obs_aok, exp_aok); end
            n_cmp++; if (obs_dok !== exp_dok) begin n_fail++; $display("FAIL b2b_data_ok c%0d got %b want %b", t, obs_dok, exp_dok); end
            if (sent < 4 && !obs_aok) drops++;
            if (obs_dok) begin
                n_cmp++;
                if (obs_rdata !== 32'hA000_0000 + 32'(done)) begin
                    n_fail++; $display("FAIL b2b_rdata n%0d got %h want %h", done, obs_rdata, 32'hA000_0000 + 32'(done));
                end
                done++;
            end
            if (sent < 4 && obs_aok) sent++;
        end
        req = 1'b0;
        n_cmp++; if (done !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", done); end
        n_cmp++; if (drops == 0) begin n_fail++; $display("FAIL b2b_full_stall got 0 stalls want >0"); end
    endtask

    task automatic test_byte_write();
        bit got = 1'b0, rd_head;
        issue(1'b1, 32'h0000_0100, 4'hF, 32'h1122_3344);
        issue(1'b1, 32'h0000_0103, 4'b1000, 32'hAB00_0000);
        issue(1'b0, 32'h0000_0100, 4'h0, 32'h0);
        for (int t = 0; t < 30 && !got; t++) begin
            rd_head = (q.size() > 0) && !q[0].wr;
            drive_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            if (obs_dok) begin
                n_cmp++; if (obs_rdata !== exp_rdata) begin n_fail++; $display("FAIL bw_rdata_model got %h want %h", obs_rdata, exp_rdata); end
                if (rd_head) begin
                    got = 1'b1;
                    n_cmp++; if (obs_rdata !== 32'hAB22_3344) begin n_fail++; $display("FAIL bw_merge got %h want ab223344", obs_rdata); end
                end
            end
        end
        n_cmp++; if (!got) begin n_fail++; $display("FAIL bw_read_timeout got none want one read completion"); end
        drain();
    endtask

    task automatic test_reset_midop();
        bit got = 1'b0;
        issue(1'b1, 32'h0000_0200, 4'hF, 32'hCAFE_F00D);
        drain();
        drive_cycle(1'b1, 1'b0, 32'h0000_0200, 4'h0, 32'h0);
        drive_cycle(1'b1, 1'b0, 32'h0000_0204, 4'h0, 32'h0);
        req = 1'b0;
        n_cmp++; if (q.size() != 2 || outstanding !== 2'd2) begin n_fail++; $display("FAIL midrst_setup got %0d want 2", outstanding); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL midrst_outstanding got %0d want 0", outstanding); end
        n_cmp++; if (data_ok !== 1'b0) begin n_fail++; $display("FAIL midrst_data_ok got %b want 0", data_ok); end
        q.delete();
        rdata_m = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int t = 0; t < 8; t++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            n_cmp++; if (obs_dok !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_data_ok c%0d got %b want 0", t, obs_dok); end
        end
        issue(1'b0, 32'h0000_0200, 4'h0, 32'h0);
        for (int t = 0; t < 20 && !got; t++) begin
            drive_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            if (obs_dok) begin
                got = 1'b1;
                n_cmp++; if (obs_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL midrst_preserved got %h want cafef00d", obs_rdata); end
            end
        end
        n_cmp++; if (!got) begin n_fail++; $display("FAIL midrst_read_timeout got none want one completion"); end
    endtask

    task automatic test_random();
        int          sent = 0, done = 0;
        bit          ready, r, w;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) issue(1'b1, 32'(4 * i), 4'hF, $urandom);
        drain();
        for (int t = 0; t < 3000 && (sent < 64 || q.size() > 0); t++) begin
            r = (sent < 64) && ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            a = $urandom;
            a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 15));
            size = 2'($urandom_range(0, 2));
            ready = (q.size() > 0) && (cyc >= q[0].hs + LAT);
            drive_cycle(r, w, a, 4'($urandom), $urandom);
`ifdef RESP_RANDOM_DELAY_EN
            n_cmp++; if (obs_dok && !ready) begin n_fail++; $display("FAIL rnd_early_data_ok c%0d got 1 want 0", t); end
`else
            n_cmp++; if (obs_dok !== exp_dok) begin n_fail++; $display("FAIL rnd_data_ok c%0d got %b want %b", t, obs_dok, exp_dok); end
            n_cmp++; if (obs_aok !== exp_aok) begin n_fail++; $display("FAIL rnd_addr_ok c%0d got %b want %b", t, obs_aok, exp_aok); end
            n_cmp++; if (int'(obs_out) != exp_out) begin n_fail++; $display("FAIL rnd_outstanding c%0d got %0d want %0d", t, obs_out, exp_out); end
`endif
            if (obs_dok) begin
                done++;
                n_cmp++; if (obs_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d got %h want %h", t, obs_rdata, exp_rdata); end
            end
            if (r && obs_aok) sent++;
        end
        req = 1'b0;
        size = 2'd2;
        n_cmp++; if (sent != 64 || done != 64) begin n_fail++; $display("FAIL rnd_completions got %0d/%0d want 64/64", done, sent); end
    endtask

    initial begin
        test_reset();
`ifndef RESP_RANDOM_DELAY_EN
        test_single_read();
        test_back_to_back();
        test_byte_write();
        test_reset_midop();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
